// File: rtl/otf_quotient_convert4.sv
// otf_quotient_convert4: back end of a radix-4 SRT divider. It turns one signed
// quotient digit per cycle into a two's-complement quotient, using the on-the-fly
// Q/QM register pair so the quotient path needs no carry-propagate adder.
// After the last digit it adds the carry-save residual, corrects the sign of the
// quotient and remainder, and pulses done.
//
// Latency: done rises 2 clocks after the edge that accepts the last digit.
// Flow control: there is no backpressure. The digit stream may stall for any
// number of cycles with digit_valid=0, and state0 aborts any division in progress.
//
// Ports:
//   clock, reset_b          rising-edge clock, synchronous active-low reset
//   state0, divisor         start/load strobe, divisor sampled on start
//   digit_valid, qdigit     one-hot signed digit {+2,+1,-1,-2}, 0000 = 0
//   sum, carry              carry-save residual, captured with the last digit
//   quotient, remainder     corrected result, held until the next FIX or reset
//   done, busy, err         result pulse, busy from start until done, sticky illegal digit
module otf_quotient_convert4 #(
  parameter int NDIG    = 4,
  parameter int RW      = 11,
  parameter int DW      = 8,
  parameter int D_ALIGN = 2
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                state0,
  input  logic [DW-1:0]       divisor,
  input  logic                digit_valid,
  input  logic [3:0]          qdigit,
  input  logic [RW-1:0]       sum,
  input  logic [RW-1:0]       carry,
  output logic [2*NDIG+1:0]   quotient,
  output logic [RW-1:0]       remainder,
  output logic                done,
  output logic                busy,
  output logic                err
);

  localparam int QW = 2*NDIG + 2;
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CONV, RESOLVE, FIX} state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   q_q, q_d;
  logic [QW-1:0]   qm_q, qm_d;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   div_q;
  logic [RW-1:0]   sum_q, carry_q, w_q;
  logic [QW-1:0]   quot_q;
  logic [RW-1:0]   rem_q;
  logic            done_q, busy_q, err_q;

  // Digit decode: 3-bit two's-complement digit value plus an illegal flag.
  logic [2:0] dig;
  logic       dig_illegal, dig_pos, dig_neg;
  logic [1:0] q_app, qm_app;

  always_comb begin
    dig         = 3'b000;
    dig_illegal = 1'b0;
    case (qdigit)
      4'b1000: dig = 3'b010;  // +2
      4'b0100: dig = 3'b001;  // +1
      4'b0010: dig = 3'b111;  // -1
      4'b0001: dig = 3'b110;  // -2
      4'b0000: dig = 3'b000;
      default: dig_illegal = 1'b1;  // more than one bit set: treated as 0
    endcase
  end

  assign dig_neg = dig[2];
  assign dig_pos = !dig[2] && (dig[1:0] != 2'b00);
  // (4+q) mod 4 and q mod 4 are the same two bits, so the Q append is just the
  // low digit bits. Likewise (3+q) mod 4 equals (q-1) mod 4 for the QM append.
  assign q_app  = dig[1:0];
  assign qm_app = dig[1:0] - 2'd1;

  // Next values of the converter pair; QM tracks Q-1 throughout.
  always_comb begin
    q_d  = dig_neg ? {qm_q[QW-3:0], q_app}  : {q_q[QW-3:0], q_app};
    qm_d = dig_pos ? {q_q[QW-3:0], qm_app}  : {qm_q[QW-3:0], qm_app};
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  logic last_dig;
  always_comb begin
    state_d = state_q;
    if (state0) begin
      state_d = CONV;
    end else begin
      case (state_q)
        CONV:    if (last_dig) state_d = RESOLVE;
        RESOLVE: state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: datapath strobes. state0 overrides everything in the same cycle.
  logic load, accept, resolve, fix;
  always_comb begin
    load     = state0;
    accept   = !state0 && (state_q == CONV) && digit_valid;
    last_dig = accept && (cnt_q == CW'(NDIG - 1));
    resolve  = !state0 && (state_q == RESOLVE);
    fix      = !state0 && (state_q == FIX);
  end

  // Negative residual: step the quotient down by one and add the aligned divisor back.
  logic [RW-1:0] rem_fix;
  assign rem_fix = w_q + (RW'(div_q) << D_ALIGN);

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      div_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      w_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= fix;
      if (load) begin
        q_q    <= '0;
        qm_q   <= '1;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        div_q  <= divisor;
        busy_q <= 1'b1;
      end else begin
        if (accept) begin
          q_q   <= q_d;
          qm_q  <= qm_d;
          cnt_q <= cnt_q + CW'(1);
          if (dig_illegal) err_q <= 1'b1;
          if (last_dig) begin
            sum_q   <= sum;
            carry_q <= carry;
          end
        end
        if (resolve) w_q <= sum_q + carry_q;
        if (fix) begin
          if (w_q[RW-1]) begin
            quot_q <= qm_q;
            rem_q  <= rem_fix;
          end else begin
            quot_q <= q_q;
            rem_q  <= w_q;
          end
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_otf_quotient_convert4.sv
module tb_otf_quotient_convert4;

  logic        clock = 1'b0;
  logic        reset_b;
  logic        state0;
  logic [7:0]  divisor;
  logic        digit_valid;
  logic [3:0]  qdigit;
  logic [10:0] sum, carry;
  logic [9:0]  quotient;
  logic [10:0] remainder;
  logic        done, busy, err;

  int errors = 0;
  int checks = 0;

  otf_quotient_convert4 dut (
    .clock(clock), .reset_b(reset_b), .state0(state0), .divisor(divisor),
    .digit_valid(digit_valid), .qdigit(qdigit), .sum(sum), .carry(carry),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Stimulus helpers only; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [7:0] d);
    state0 = 1'b1; divisor = d; digit_valid = 1'b0;
    tick();
    state0 = 1'b0;
  endtask

  task automatic send(input logic [3:0] q, input logic [10:0] s, input logic [10:0] c);
    digit_valid = 1'b1; qdigit = q; sum = s; carry = c;
    tick();
    digit_valid = 1'b0; qdigit = 4'b0000;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; state0 = 1'b0; divisor = '0; digit_valid = 1'b0;
    qdigit = '0; sum = '0; carry = '0;
    tick(); tick();
    checks++; if (quotient !== 10'h000) begin errors++; $display("FAIL reset_quot: got %h want 000", quotient); end
    checks++; if (remainder !== 11'h000) begin errors++; $display("FAIL reset_rem: got %h want 000", remainder); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (dut.qm_q !== 10'h3FF) begin errors++; $display("FAIL reset_qm: got %h want 3ff", dut.qm_q); end
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_positive();
    start(8'h80);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy_start: got %b want 1", busy); end
    send(4'b1000, 11'h000, 11'h000);
    send(4'b0010, 11'h000, 11'h000);
    send(4'b0000, 11'h000, 11'h000);
    send(4'b0100, 11'h010, 11'h000);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_early0: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_early1: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pos_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h071) begin errors++; $display("FAIL pos_quot: got %h want 071", quotient); end
    checks++; if (remainder !== 11'h010) begin errors++; $display("FAIL pos_rem: got %h want 010", remainder); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pos_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pos_busy_end: got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_width: got %b want 0", done); end
  endtask

  task automatic test_neg_residual();
    start(8'h80);
    send(4'b1000, 11'h000, 11'h000);
    send(4'b0010, 11'h000, 11'h000);
    send(4'b0000, 11'h000, 11'h000);
    send(4'b0100, 11'h7F0, 11'h008);
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL negres_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h070) begin errors++; $display("FAIL negres_quot: got %h want 070", quotient); end
    checks++; if (remainder !== 11'h1F8) begin errors++; $display("FAIL negres_rem: got %h want 1f8", remainder); end
  endtask

  task automatic test_neg_leading();
    logic [3:0] digs [4];
    logic [9:0] exp_q [4];
    logic [9:0] exp_qm [4];
    digs   = '{4'b0010, 4'b1000, 4'b1000, 4'b1000};
    exp_q  = '{10'h3FF, 10'h3FE, 10'h3FA, 10'h3EA};
    exp_qm = '{10'h3FE, 10'h3FD, 10'h3F9, 10'h3E9};
    start(8'h40);
    for (int i = 0; i < 4; i++) begin
      send(digs[i], 11'h004, 11'h000);
      checks++; if (dut.q_q !== exp_q[i]) begin errors++; $display("FAIL negl_q%0d: got %h want %h", i, dut.q_q, exp_q[i]); end
      checks++; if (dut.qm_q !== exp_qm[i]) begin errors++; $display("FAIL negl_qm%0d: got %h want %h", i, dut.qm_q, exp_qm[i]); end
    end
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL negl_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h3EA) begin errors++; $display("FAIL negl_quot: got %h want 3ea", quotient); end
    checks++; if (remainder !== 11'h004) begin errors++; $display("FAIL negl_rem: got %h want 004", remainder); end
  endtask

  task automatic test_stall_illegal();
    start(8'h20);
    send(4'b0100, 11'h000, 11'h000);
    tick(); tick(); tick();
    send(4'b1100, 11'h000, 11'h000);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_err_set: got %b want 1", err); end
    tick(); tick(); tick();
    send(4'b0010, 11'h000, 11'h000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    send(4'b1000, 11'h005, 11'h003);
    // A digit offered right after the last one must not overwrite the residual.
    send(4'b1000, 11'h7FF, 11'h7FF);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_early: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h03E) begin errors++; $display("FAIL stall_quot: got %h want 03e", quotient); end
    checks++; if (remainder !== 11'h008) begin errors++; $display("FAIL stall_rem: got %h want 008", remainder); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_err_sticky: got %b want 1", err); end
    // Digits in IDLE are ignored and the result holds.
    send(4'b0100, 11'h000, 11'h000);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_width: got %b want 0", done); end
    tick(); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_idle_done: got %b want 0", done); end
    checks++; if (quotient !== 10'h03E) begin errors++; $display("FAIL stall_hold: got %h want 03e", quotient); end
  endtask

  task automatic test_abort_restart();
    start(8'h10);
    send(4'b1000, 11'h000, 11'h000);
    send(4'b0001, 11'h000, 11'h000);
    start(8'h10);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clr: got %b want 0", err); end
    for (int i = 0; i < 4; i++) send(4'b0100, 11'h002, 11'h000);
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h055) begin errors++; $display("FAIL abort_quot: got %h want 055", quotient); end
    checks++; if (remainder !== 11'h002) begin errors++; $display("FAIL abort_rem: got %h want 002", remainder); end
    // Restart in the done cycle; previous result must stay visible.
    start(8'h10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
    checks++; if (quotient !== 10'h055) begin errors++; $display("FAIL restart_hold: got %h want 055", quotient); end
    for (int i = 0; i < 3; i++) send(4'b0001, 11'h000, 11'h000);
    send(4'b0001, 11'h7FC, 11'h000);
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h355) begin errors++; $display("FAIL restart_quot: got %h want 355", quotient); end
    checks++; if (remainder !== 11'h03C) begin errors++; $display("FAIL restart_rem: got %h want 03c", remainder); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start(8'h80);
    for (int i = 0; i < 3; i++) send(4'b0100, 11'h000, 11'h000);
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    checks++; if (quotient !== 10'h000) begin errors++; $display("FAIL rstmid_quot: got %h want 000", quotient); end
    checks++; if (remainder !== 11'h000) begin errors++; $display("FAIL rstmid_rem: got %h want 000", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      send(4'b0100, 11'h001, 11'h000);
      if (done) seen_done++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
    start(8'h80);
    send(4'b0100, 11'h000, 11'h000);
    send(4'b0000, 11'h000, 11'h000);
    send(4'b0000, 11'h000, 11'h000);
    send(4'b0000, 11'h001, 11'h000);
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b want 1", done); end
    checks++; if (quotient !== 10'h040) begin errors++; $display("FAIL rstmid_quot2: got %h want 040", quotient); end
    checks++; if (remainder !== 11'h001) begin errors++; $display("FAIL rstmid_rem2: got %h want 001", remainder); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_neg_residual();
    test_neg_leading();
    test_stall_illegal();
    test_abort_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
